// File: rtl/seq_alu.sv
// seq_alu: signed multi-cycle ALU; ADD/SUB in one cycle, shift-add MUL and restoring DIV over WIDTH cycles.
// Optional feature macro: SEQ_ALU_REM_EN adds the rem output (DIV remainder, or a on divide-by-zero).
module seq_alu #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] DIV0_RESULT = '1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              op,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] result,
  output logic                    carry,
  output logic                    zero,
  output logic                    div0
`ifdef SEQ_ALU_REM_EN
  ,
  output logic signed [WIDTH-1:0] rem
`endif
);
  localparam int            CW     = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [1:0]    OP_ADD = 2'b00;
  localparam logic [1:0]    OP_SUB = 2'b01;
  localparam logic [1:0]    OP_MUL = 2'b10;
  localparam logic [1:0]    OP_DIV = 2'b11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic                 done_q, carry_q, zero_q, div0_q;
  logic [WIDTH-1:0]     result_q;
  logic                 mul_q, sign_q;
  logic [2*WIDTH-1:0]   mcand_q, acc_q;
  logic [WIDTH-1:0]     mplier_q, dvsr_q, quo_q, prem_q;
`ifdef SEQ_ALU_REM_EN
  logic                 a_neg_q;
  logic [WIDTH-1:0]     rem_q, rem_d;
`endif

  logic                 accept, fin, carry_d, div0_d;
  logic [WIDTH-1:0]     res_d;
  logic [WIDTH:0]       sum, shl, trial;
  logic [2*WIDTH-1:0]   acc_step, prod;
  logic [WIDTH-1:0]     prem_step, quo_step, quo_s;

  // Magnitude of a signed value; MIN maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? WIDTH'(-x) : WIDTH'(x);
  endfunction

  function automatic logic mul_ovf(input logic [2*WIDTH-1:0] p);
    logic [WIDTH:0] top;
    top = p[2*WIDTH-1:WIDTH-1];
    return !((&top) || !(|top));
  endfunction

  always_comb begin
    accept    = (state_q == IDLE) && start;
    sum       = {1'b0, a} + {1'b0, (op[0] ? ~b : b)} + {{WIDTH{1'b0}}, op[0]};
    acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod      = sign_q ? -acc_step : acc_step;
    shl       = {prem_q, quo_q[WIDTH-1]};
    trial     = shl - {1'b0, dvsr_q};
    prem_step = trial[WIDTH] ? shl[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_step  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    quo_s     = sign_q ? -quo_step : quo_step;
    fin       = 1'b0;
    res_d     = '0;
    carry_d   = 1'b0;
    div0_d    = 1'b0;
`ifdef SEQ_ALU_REM_EN
    rem_d     = '0;
`endif
    if (accept) begin
      case (op)
        OP_ADD, OP_SUB: begin
          fin     = 1'b1;
          res_d   = sum[WIDTH-1:0];
          carry_d = sum[WIDTH];
        end
        OP_DIV: begin
          if (b == '0) begin
            fin    = 1'b1;
            res_d  = DIV0_RESULT;
            div0_d = 1'b1;
`ifdef SEQ_ALU_REM_EN
            rem_d  = a;
`endif
          end
        end
        default: ;
      endcase
    end else if (state_q == RUN && cnt_q == LAST) begin
      fin = 1'b1;
      if (mul_q) begin
        res_d   = prod[WIDTH-1:0];
        carry_d = mul_ovf(prod);
      end else begin
        // Only MIN / -1 yields a positive quotient magnitude of 2^(WIDTH-1).
        res_d   = quo_s;
        carry_d = ~sign_q & quo_step[WIDTH-1];
`ifdef SEQ_ALU_REM_EN
        rem_d   = a_neg_q ? -prem_step : prem_step;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      div0_q   <= 1'b0;
`ifdef SEQ_ALU_REM_EN
      rem_q    <= '0;
`endif
    end else begin
      done_q <= fin;
      if (fin) begin
        result_q <= res_d;
        carry_q  <= carry_d;
        zero_q   <= (res_d == '0);
`ifdef SEQ_ALU_REM_EN
        rem_q    <= rem_d;
`endif
      end
      if (accept) begin
        div0_q   <= div0_d;
        cnt_q    <= '0;
        mul_q    <= ~op[0];
        sign_q   <= a[WIDTH-1] ^ b[WIDTH-1];
        mcand_q  <= {{WIDTH{1'b0}}, mag(a)};
        mplier_q <= mag(b);
        acc_q    <= '0;
        dvsr_q   <= mag(b);
        quo_q    <= mag(a);
        prem_q   <= '0;
`ifdef SEQ_ALU_REM_EN
        a_neg_q  <= a[WIDTH-1];
`endif
        if (op == OP_MUL || (op == OP_DIV && b != '0)) state_q <= RUN;
      end else if (state_q == RUN) begin
        cnt_q    <= cnt_q + CW'(1);
        acc_q    <= acc_step;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        prem_q   <= prem_step;
        quo_q    <= quo_step;
        if (cnt_q == LAST) state_q <= IDLE;
      end
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign div0   = div0_q;
`ifdef SEQ_ALU_REM_EN
  assign rem    = rem_q;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=16): directed corner cases, reset abort, random ops vs integer model.
module tb_seq_alu;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, carry, zero, div0;
  logic [W-1:0] result;
`ifdef SEQ_ALU_REM_EN
  logic [W-1:0] rem;
`endif

  int n_vec = 0;
  int n_err = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry),
    .zero   (zero),
`ifdef SEQ_ALU_REM_EN
    .rem    (rem),
`endif
    .div0   (div0)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within cycle budget");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 12)
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'hFFFF;
      3: return 16'h8000;
      4: return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Issues one op, expectations from plain integer arithmetic; scrambles inputs and
  // pulses start while busy to confirm operands are latched and extra starts ignored.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0]   full;
    longint       p, q, r;
    logic [W-1:0] er, erem;
    logic         ec, ed0;
    int           sa, sb, lat, elat;
    sa = int'($signed(x));
    sb = int'($signed(y));
    er = '0; erem = '0; ec = 1'b0; ed0 = 1'b0; elat = 0;
    case (o)
      2'b00: begin
        full = {1'b0, x} + {1'b0, y};
        er = full[W-1:0]; ec = full[W];
      end
      2'b01: begin
        full = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        er = full[W-1:0]; ec = full[W];
      end
      2'b10: begin
        p = longint'(sa) * longint'(sb);
        er = p[W-1:0]; ec = (p > 32767) || (p < -32768); elat = W;
      end
      default: begin
        if (y == '0) begin
          er = '1; ed0 = 1'b1; erem = x;
        end else begin
          q = longint'(sa) / longint'(sb);
          r = longint'(sa) % longint'(sb);
          er = q[W-1:0]; erem = r[W-1:0]; ec = (q > 32767); elat = W;
        end
      end
    endcase
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    check("busy_after_start", {31'd0, busy}, {31'd0, (elat > 0)});
    while (!done && lat < 3*W) begin
      a = W'($urandom); b = W'($urandom); op = 2'($urandom);
      start = (lat < elat - 1) ? 1'($urandom % 2) : 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("latency", lat, elat);
    check("done", {31'd0, done}, 32'd1);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check("result", {16'd0, result}, {16'd0, er});
    check("carry", {31'd0, carry}, {31'd0, ec});
    check("zero", {31'd0, zero}, {31'd0, (er == '0)});
    check("div0", {31'd0, div0}, {31'd0, ed0});
`ifdef SEQ_ALU_REM_EN
    check("rem", {16'd0, rem}, {16'd0, erem});
`endif
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n_done;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_flags", {29'd0, carry, zero, div0}, 32'd0);
    rst = 1'b0;

    run_op(2'b00, 16'h7FFF, 16'h0001);
    check("add_ovf_res", {16'd0, result}, 32'h8000);
    check("add_ovf_carry", {31'd0, carry}, 32'd0);
    idle_cycle();
    run_op(2'b01, 16'd5, 16'd5);
    check("sub_zero", {31'd0, zero}, 32'd1);
    check("sub_noborrow", {31'd0, carry}, 32'd1);
    run_op(2'b10, 16'hFFFD, 16'd7);
    check("mul_neg_res", {16'd0, result}, 32'hFFEB);
    run_op(2'b10, 16'd300, 16'd300);
    check("mul_ovf", {31'd0, carry}, 32'd1);
    run_op(2'b11, 16'hFFF9, 16'd2);
    check("div_neg_res", {16'd0, result}, 32'hFFFD);
`ifdef SEQ_ALU_REM_EN
    check("div_neg_rem", {16'd0, rem}, 32'hFFFF);
`endif
    run_op(2'b11, 16'h8000, 16'hFFFF);
    check("div_min_res", {16'd0, result}, 32'h8000);
    check("div_min_carry", {31'd0, carry}, 32'd1);
    run_op(2'b11, 16'd5, 16'd0);
    check("div0_flag", {31'd0, div0}, 32'd1);
    check("div0_res", {16'd0, result}, 32'hFFFF);
    run_op(2'b00, 16'd1, 16'd1);
    check("div0_cleared", {31'd0, div0}, 32'd0);
    run_op(2'b11, 16'd100, 16'd7);
    run_op(2'b00, 16'h1234, 16'h0001);
    check("b2b_add_res", {16'd0, result}, 32'h1235);
    idle_cycle();

    // Abort a MUL with reset sampled in its 5th cycle.
    op = 2'b10; a = 16'd100; b = 16'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", {16'd0, result}, 32'd0);
    check("abort_flags", {29'd0, carry, zero, div0}, 32'd0);
    n_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);

    // Reset has priority over a simultaneous start.
    rst = 1'b1; start = 1'b1; op = 2'b00; a = 16'd3; b = 16'd4;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst_start_done", {31'd0, done}, 32'd0);
    check("rst_start_res", {16'd0, result}, 32'd0);
    idle_cycle();

    for (int i = 0; i < 2000; i++) begin
      run_op(2'($urandom), pick(), pick());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
